// File: rtl/carry_select_pipe.sv
// rtl/carry_select_pipe.sv - pipelined carry-select adder with valid/ready handshake
//
// Purpose:
//    Computes {c_out, o_sum} = i_a + i_b + c_in over STAGES pipeline stages.
//    Stage k adds operand slice k (WIDTH/STAGES bits) using BLK-bit
//    carry-select blocks. The inter-stage carry, the partial sum and the
//    not-yet-added upper operand bits travel in pipeline registers. The whole
//    pipeline advances when o_ready is high, so bubbles advance too.
//
// Parameters:
//    WIDTH  - operand and sum width
//    BLK    - carry-select block width
//    STAGES - number of pipeline stages (= latency in cycles)
//
// Ports:
//    i_clk   in   clock, rising edge
//    i_rst   in   synchronous active-high reset
//    i_a     in   operand A [WIDTH]
//    i_b     in   operand B [WIDTH]
//    c_in    in   carry into bit 0
//    i_valid in   operands valid
//    o_ready out  input accepted this cycle when i_valid is high
//    o_sum   out  registered sum [WIDTH]
//    c_out   out  registered carry out of the MSB
//    o_ovf   out  signed overflow, only with CSP_OVF_EN defined
//    o_valid out  o_sum/c_out hold a result
//    i_ready in   downstream accepts the result
//
// Build option:
//    CSP_OVF_EN - adds the registered o_ovf output.

module carry_select_pipe #(
   parameter int WIDTH  = 16,
   parameter int BLK    = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             c_in,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             c_out,
`ifdef CSP_OVF_EN
   output logic             o_ovf,
`endif
   output logic             o_valid,
   input  logic             i_ready
);

   localparam int SLICE = WIDTH / STAGES;
   localparam int NBLK  = SLICE / BLK;

   if (((WIDTH % STAGES) != 0) || ((SLICE % BLK) != 0)) begin : g_bad_cfg
      $fatal(1, "carry_select_pipe: WIDTH must divide by STAGES and WIDTH/STAGES by BLK");
   end

   // One slice of carry-select addition: every block forms both candidate
   // sums up front, the ripple between blocks is only a mux select.
   function automatic logic [SLICE:0] csel_add(
      input logic [SLICE-1:0] a,
      input logic [SLICE-1:0] b,
      input logic             cin
   );
      logic [BLK:0]   s0;
      logic [BLK:0]   s1;
      logic [SLICE-1:0] sum;
      logic           cy;
      cy  = cin;
      sum = '0;
      for (int j = 0; j < NBLK; j++) begin
         s0 = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]};
         s1 = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
         sum[j*BLK +: BLK] = cy ? s1[BLK-1:0] : s0[BLK-1:0];
         cy = cy ? s1[BLK] : s0[BLK];
      end
      return {cy, sum};
   endfunction

   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_cy  [STAGES];
   logic             r_v   [STAGES];

   logic [WIDTH-1:0] w_a_in [STAGES];
   logic [WIDTH-1:0] w_b_in [STAGES];
   logic [WIDTH-1:0] w_s_in [STAGES];
   logic             w_c_in [STAGES];
   logic             w_v_in [STAGES];
   logic [SLICE:0]   w_res  [STAGES];
   logic [WIDTH-1:0] w_s_nx [STAGES];
   logic             w_c_nx [STAGES];

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            w_a_in[k] = i_a;
            w_b_in[k] = i_b;
            w_s_in[k] = '0;
            w_c_in[k] = c_in;
            w_v_in[k] = i_valid;
         end else begin
            // index kept in range even in the branch not taken for k == 0
            w_a_in[k] = r_a[(k == 0) ? 0 : k - 1];
            w_b_in[k] = r_b[(k == 0) ? 0 : k - 1];
            w_s_in[k] = r_sum[(k == 0) ? 0 : k - 1];
            w_c_in[k] = r_cy[(k == 0) ? 0 : k - 1];
            w_v_in[k] = r_v[(k == 0) ? 0 : k - 1];
         end
         w_res[k] = csel_add(w_a_in[k][k*SLICE +: SLICE],
                             w_b_in[k][k*SLICE +: SLICE],
                             w_c_in[k]);
         // slices at and above k are still zero in the incoming partial sum
         w_s_nx[k] = w_s_in[k];
         w_s_nx[k][k*SLICE +: SLICE] = w_res[k][SLICE-1:0];
         w_c_nx[k] = w_res[k][SLICE];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k]   <= 1'b0;
            r_cy[k]  <= 1'b0;
            r_sum[k] <= '0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
         end
      end else if (o_ready) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k]   <= w_v_in[k];
            r_cy[k]  <= w_c_nx[k];
            r_sum[k] <= w_s_nx[k];
            r_a[k]   <= w_a_in[k];
            r_b[k]   <= w_b_in[k];
         end
      end
   end

`ifdef CSP_OVF_EN
   logic r_ovf;

   // operand MSBs are taken at the last stage input so the flag lines up
   // with the sum it describes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (o_ready) begin
         r_ovf <= (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1]) &&
                  (w_s_nx[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);
      end
   end

   assign o_ovf = r_ovf;
`endif

   assign o_sum   = r_sum[STAGES-1];
   assign c_out   = r_cy[STAGES-1];
   assign o_valid = r_v[STAGES-1];
   // forced high during reset so upstream never sees a stall there
   assign o_ready = i_rst || !o_valid || i_ready;

endmodule

// File: tb/tb_carry_select_pipe.sv
// tb/tb_carry_select_pipe.sv - self-checking bench for carry_select_pipe

module tb_carry_select_pipe;

   localparam int STAGES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a, b;
   logic        cin, vld, rdy;
   logic        o_ready, c_out, o_valid;
   logic [15:0] o_sum;
`ifdef CSP_OVF_EN
   logic        o_ovf;
   logic        o_ovf4;
`endif

   logic [3:0]  a4, b4, sum4;
   logic        c4, v4, ready4, cout4, valid4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned n;
      logic [15:0] sum;
      logic        cy;
      logic        ovf;
   } item_t;

   item_t q[$];
   int unsigned adv_cnt = 0;
   bit started = 0;
   logic hist [16];

   always #5 clk = ~clk;

   carry_select_pipe dut (
      .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .c_in(cin),
      .i_valid(vld), .o_ready(o_ready), .o_sum(o_sum), .c_out(c_out),
`ifdef CSP_OVF_EN
      .o_ovf(o_ovf),
`endif
      .o_valid(o_valid), .i_ready(rdy)
   );

   carry_select_pipe #(.WIDTH(4), .BLK(2), .STAGES(1)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_a(a4), .i_b(b4), .c_in(c4),
      .i_valid(v4), .o_ready(ready4), .o_sum(sum4), .c_out(cout4),
`ifdef CSP_OVF_EN
      .o_ovf(o_ovf4),
`endif
      .o_valid(valid4), .i_ready(1'b1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xv);
      a = xa;
      b = xb;
      cin = xc;
      vld = xv;
   endtask

   // Single operation into an empty pipeline with hand-computed result.
   task automatic one_op(input string name, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input logic [15:0] es, input logic ec, input logic eo);
      @(posedge clk); #1;
      drive(xa, xb, xc, 1'b1);
      rdy = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      @(negedge clk);
      chk({name, "_early"}, 32'(o_valid), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk({name, "_valid"}, 32'(o_valid), 32'(1));
      chk({name, "_sum"}, 32'(o_sum), 32'(es));
      chk({name, "_cout"}, 32'(c_out), 32'(ec));
`ifdef CSP_OVF_EN
      chk({name, "_ovf"}, 32'(o_ovf), 32'(eo));
`else
      if (eo === 1'bx) chk({name, "_ovf_arg"}, 32'(eo), 32'(0));
`endif
   endtask

   // Reference: queue of accepted sums; an item is visible once the pipeline
   // has advanced STAGES times since its acceptance.
   initial begin : compare
      bit ev;
      item_t it;
      logic [16:0] full;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            started = 1;
            chk("ready_in_reset", 32'(o_ready), 32'(1));
         end else if (started) begin
            ev = (q.size() > 0) && (q[0].n + STAGES == adv_cnt);
            chk("m_valid", 32'(o_valid), 32'(ev));
            if (ev) begin
               chk("m_sum", 32'(o_sum), 32'(q[0].sum));
               chk("m_cout", 32'(c_out), 32'(q[0].cy));
`ifdef CSP_OVF_EN
               chk("m_ovf", 32'(o_ovf), 32'(q[0].ovf));
`endif
            end
            chk("m_ready", 32'(o_ready), 32'(!ev || rdy));
            if (ev && rdy) void'(q.pop_front());
            if ((!ev || rdy) && vld) begin
               full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
               it.n = adv_cnt;
               it.sum = full[15:0];
               it.cy = full[16];
               it.ovf = (a[15] == b[15]) && (full[15] != a[15]);
               q.push_back(it);
            end
            if (!ev || rdy) adv_cnt++;
         end
      end
   end

   initial begin
      logic [15:0] xa;
      logic [4:0]  e4;
      int unsigned j;
      rst = 1'b1;
      drive(16'h0, 16'h0, 1'b0, 1'b0);
      rdy = 1'b1;
      a4 = 4'h0; b4 = 4'h0; c4 = 1'b0; v4 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'(0));
      chk("rst_sum", 32'(o_sum), 32'(0));
      chk("rst_cout", 32'(c_out), 32'(0));
      chk("rst_ready", 32'(o_ready), 32'(1));
      chk("rst_valid4", 32'(valid4), 32'(0));

      // full carry chain across every block and stage
      one_op("ones", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

      // stream with a 3-cycle downstream stall after the first result
      @(posedge clk); #1;
      drive(16'h0001, 16'h0001, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(16'h8000, 16'h8000, 1'b0, 1'b1);
      @(negedge clk);
      chk("st1_valid", 32'(o_valid), 32'(1));
      chk("st1_sum", 32'(o_sum), 32'h0002);
      chk("st1_cout", 32'(c_out), 32'(0));
      @(posedge clk); #1;
      vld = 1'b0;
      rdy = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("stall_ready", 32'(o_ready), 32'(0));
         chk("stall_valid", 32'(o_valid), 32'(1));
         chk("stall_sum", 32'(o_sum), 32'h0100);
         chk("stall_cout", 32'(c_out), 32'(0));
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("st2_sum", 32'(o_sum), 32'h0100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("st3_valid", 32'(o_valid), 32'(1));
      chk("st3_sum", 32'(o_sum), 32'h0000);
      chk("st3_cout", 32'(c_out), 32'(1));

      // alternating valid pattern, delayed by STAGES at the output
      for (int t = 0; t < 14; t++) begin
         @(posedge clk); #1;
         drive(16'($urandom), 16'($urandom), 1'($urandom), (t < 10) && (t % 2 == 0));
         hist[t] = vld;
         @(negedge clk);
         if (t >= 2) chk("alt_valid", 32'(o_valid), 32'(hist[t-2]));
      end

      // reset one cycle after acceptance discards the operation
      @(posedge clk); #1;
      drive(16'h1234, 16'h1111, 1'b0, 1'b1);
      @(posedge clk); #1;
      vld = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("rst_flush_valid", 32'(o_valid), 32'(0));
         if (s < 2) begin
            @(posedge clk); #1;
         end
      end
      one_op("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

`ifdef CSP_OVF_EN
      one_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      one_op("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`endif

      // randomized traffic with stalls, bubbles, corner operands and resets
      for (int t = 0; t < 1500; t++) begin
         @(posedge clk); #1;
         case ($urandom_range(0, 3))
            0: xa = 16'hFFFF;
            1: xa = 16'h0000;
            default: xa = 16'($urandom);
         endcase
         drive(xa, ($urandom_range(0, 3) == 0) ? 16'hFFFF - xa : 16'($urandom),
               1'($urandom), $urandom_range(0, 3) != 0);
         rdy = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 199) == 0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      vld = 1'b0;
      rdy = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("drain_empty", 32'(q.size()), 32'(0));

      // exhaustive 4-bit instance, single stage, back to back
      for (int i = 0; i <= 512; i++) begin
         @(posedge clk); #1;
         j = 32'(i);
         v4 = (i < 512);
         {c4, b4, a4} = j[8:0];
         @(negedge clk);
         if (i > 0) begin
            j = 32'(i - 1);
            e4 = {1'b0, j[3:0]} + {1'b0, j[7:4]} + {4'd0, j[8]};
            chk("w4_sum", 32'({valid4, cout4, sum4}), 32'({1'b1, e4}));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
